// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for a CPU data port.
// A request is captured in IDLE and walks through ACC0 (word 0), optionally
// ACC1 (word 1, dword only), then RESP. ready/err/readdata are registered,
// so the completion pulse appears the cycle after RESP.
// All writes of a request commit together on the edge that leaves the
// last access state. A misaligned dword (dataadr[2]=1) writes nothing
// and completes with err=1 and readdata=0.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   req             request strobe, only sampled in IDLE
//   memwrite[1:0]   bit0 writes word 0, bit1 writes word 1 (dword only)
//   dword           1 = 64-bit access
//   dataadr[N]      byte address; word index = dataadr[log2(DEPTH)+1:2]
//   writedata[N]    store data, low half -> word 0, high half -> word 1
//   ready           one-cycle completion pulse
//   err             misaligned dword, valid with ready
//   readdata[N]     load data, held between completions
//   checkma[8]      debug word index
//   checkm[32]      debug read data
//
// Build option: define DMEM_CHECK_PORT_EN to enable the checkma/checkm debug
// read port; otherwise checkm is tied to 0 and checkma is ignored.
module dmem_responder #(
  parameter int N     = 64,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [1:0]   memwrite,
  input  logic         dword,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  output logic         ready,
  output logic         err,
  output logic [N-1:0] readdata,
  input  logic [7:0]   checkma,
  output logic [31:0]  checkm
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  typedef struct packed {
    logic [1:0]    we;
    logic          dword;
    logic          odd;     // dataadr[2]: dword misalignment
    logic [AW-1:0] idx;
    logic [63:0]   wdata;
  } req_t;

  state_t        state, state_nx;
  req_t          r;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd0, rd1;
  logic [AW-1:0] idx1;
  logic          last, bad, commit;

  // Address bits outside the word index are don't-care (aliasing).
  logic unused_adr;
  assign unused_adr = ^{dataadr[N-1:AW+2], dataadr[1:0]};

  assign idx1   = r.idx + AW'(1);   // wraps modulo DEPTH
  assign bad    = r.dword & r.odd;
  assign last   = (state == ACC0 && !r.dword) || (state == ACC1);
  assign commit = last & ~bad;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = ACC0;
      ACC0:    state_nx = r.dword ? ACC1 : RESP;
      ACC1:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture only in IDLE; the captured request is frozen while busy.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      r.we    <= memwrite;
      r.dword <= dword;
      r.odd   <= dataadr[2];
      r.idx   <= dataadr[AW+1:2];
      r.wdata <= writedata[63:0];
    end
  end

  // Reads sample pre-write contents: the commit edge is the same edge as
  // (or later than) the last read, and both use nonblocking updates.
  always_ff @(posedge clk) begin
    if (state == ACC0) rd0 <= mem[r.idx];
    if (state == ACC1) rd1 <= mem[idx1];
  end

  // Storage is never reset; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (reset && commit) begin
      if (r.we[0])            mem[r.idx] <= r.wdata[31:0];
      if (r.we[1] && r.dword) mem[idx1]  <= r.wdata[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready    <= 1'b0;
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      ready <= (state == RESP);
      err   <= (state == RESP) && bad;
      if (state == RESP)
        readdata <= bad     ? '0 :
                    r.dword ? N'({rd1, rd0}) : N'({32'b0, rd0});
    end
  end

`ifdef DMEM_CHECK_PORT_EN
  logic [AW-1:0] ck_idx;
  assign ck_idx = AW'(checkma);
  assign checkm = mem[ck_idx];
`else
  logic unused_ck;
  assign unused_ck = ^checkma;
  assign checkm    = 32'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter N, default 64, data/address width of the CPU data port.
REQ-002 Parameter DEPTH, default 256, number of 32-bit storage words (power of two).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req  in  1  request strobe from CPU data port.
REQ-006 memwrite  in  2  bit0 = write low word at address, bit1 = write high word at address+4 (dword only); 2'b00 = read.
REQ-007 dword  in  1  1 = 64-bit access, 0 = 32-bit access.
REQ-008 dataadr  in  N  byte address.
REQ-009 writedata  in  N  store data; low 32 bits to word 0, high 32 bits to word 1.
REQ-010 ready  out  1  one-cycle completion pulse.
REQ-011 err  out  1  alignment error, valid only while ready=1.
REQ-012 readdata  out  N  load data, held between completions.
REQ-013 checkma  in  8  debug word index.
REQ-014 checkm  out  32  debug read data.

Function
REQ-015 Word index SHALL be dataadr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses alias modulo 4*DEPTH bytes.
REQ-016 FSM states SHALL be IDLE, ACC0, ACC1, RESP.
REQ-017 In IDLE with req=1, the block SHALL capture memwrite, dword, dataadr and writedata and enter ACC0; with req=0 it SHALL stay in IDLE.
REQ-018 req SHALL be ignored in ACC0, ACC1 and RESP; the captured request SHALL not change while busy.
REQ-019 ACC0 SHALL read word 0 and go to ACC1 if dword=1, else to RESP.
REQ-020 ACC1 SHALL read word 1 (index+1, wrapping modulo DEPTH) and go to RESP.
REQ-021 All writes of a request SHALL commit together on the edge leaving the last access state: word 0 if memwrite[0], word 1 if memwrite[1] and dword.
REQ-022 memwrite[1] with dword=0 SHALL be ignored.
REQ-023 RESP SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-024 A request accepted at edge k SHALL see ready high in the cycle after edge k+2 for a 32-bit access and after edge k+3 for a 64-bit access.
REQ-025 32-bit reads SHALL return {32'b0, word0}; 64-bit reads SHALL return {word1, word0}; on writes, readdata SHALL return the pre-write contents.
REQ-026 A dword request with dataadr[2]=1 SHALL perform no write, set err=1 with ready, and load readdata with 0.
REQ-027 A new req in the RESP cycle SHALL be ignored; back-to-back throughput is one request per 3 or 4 cycles.
REQ-028 checkm SHALL be combinational from storage[checkma mod DEPTH]; on a same-cycle write commit it SHALL show the old value.

Reset
REQ-029 With reset=0 at a clock edge: state SHALL become IDLE, and ready, err and readdata SHALL become 0.
REQ-030 Reset during ACC0/ACC1 SHALL abort the request with no write committed.
REQ-031 Storage contents SHALL not be affected by reset.

Configuration
REQ-032 Macro DMEM_CHECK_PORT_EN defined: checkma/checkm SHALL behave per REQ-028.
REQ-033 DMEM_CHECK_PORT_EN undefined: ports SHALL remain present, checkm SHALL be tied to 0 and checkma SHALL be ignored.

Verification
REQ-034 Word write adr 0x10 data 0x1122334455667788 memwrite=01 dword=0, then read -> readdata 0x0000000055667788, ready 2 cycles after each accept.
REQ-035 Dword write adr 0x20 memwrite=11 data 0xAABBCCDD00112233, then dword read -> 0xAABBCCDD00112233 after 3 cycles; checkma=8 -> 0x00112233 and checkma=9 -> 0xAABBCCDD.
REQ-036 Dword read at adr 0x24 -> ready with err=1, readdata 0, and no storage change.
REQ-037 Assert reset=0 in the ACC1 cycle of a dword write to 0x30 -> no write (checkm unchanged), outputs 0, FSM in IDLE.
REQ-038 Hold req=1 continuously with alternating reads -> one accept per 3 cycles, with no requests captured while busy.
REQ-039 Write to adr 0x400 with DEPTH=256 -> aliases to word 0, and checkma=0 shows the written data.
